// File: rtl/spu_reg_file.sv
// Unified SPU register file: two writeback ports, three registered read ports
// with same-edge write bypass, zero-initialised by a sequential sweep after reset.
module spu_reg_file #(
  parameter int NUM_REGS = 128,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:ADDR_W-1] ra_addr,
  input  logic [0:ADDR_W-1] rb_addr,
  input  logic [0:ADDR_W-1] rc_addr,
  output logic [0:DATA_W-1] ra,
  output logic [0:DATA_W-1] rb,
  output logic [0:DATA_W-1] rc,
  input  logic [0:DATA_W-1] rt_wb_e,
  input  logic [0:ADDR_W-1] rt_addr_wb_e,
  input  logic              reg_write_wb_e,
  input  logic [0:DATA_W-1] rt_wb_o,
  input  logic [0:ADDR_W-1] rt_addr_wb_o,
  input  logic              reg_write_wb_o,
  output logic              init_busy,
  output logic              wr_collision
);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state_reg, state_next;
  logic [0:ADDR_W-1] init_cnt_reg;
  logic              collision_reg;
  logic [0:DATA_W-1] mem [NUM_REGS];
  logic [0:ADDR_W-1] rd_addr [3];
  logic [0:DATA_W-1] rd_next [3];
  logic [0:DATA_W-1] rd_data_reg [3];

  logic ready, wr_e, wr_o;
  assign ready = (state_reg == S_READY);
  assign wr_e  = ready && reg_write_wb_e;
  assign wr_o  = ready && reg_write_wb_o;

  always_comb begin
    state_next = state_reg;
    if (state_reg == S_INIT && init_cnt_reg == ADDR_W'(NUM_REGS - 1))
      state_next = S_READY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_INIT;
      init_cnt_reg  <= '0;
      collision_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      if (state_reg == S_INIT)
        init_cnt_reg <= init_cnt_reg + ADDR_W'(1);
      collision_reg <= wr_e && wr_o && (rt_addr_wb_e == rt_addr_wb_o);
    end
  end

  // Storage has no reset; the sweep clears it. Odd write is last so it wins a tie.
  always_ff @(posedge clk) begin
    if (state_reg == S_INIT) begin
      mem[init_cnt_reg] <= '0;
    end else begin
      if (wr_e) mem[rt_addr_wb_e] <= rt_wb_e;
      if (wr_o) mem[rt_addr_wb_o] <= rt_wb_o;
    end
  end

  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;
  assign rd_addr[2] = rc_addr;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rd
    always_comb begin
      rd_next[gi] = mem[rd_addr[gi]];
      if (!ready)
        rd_next[gi] = '0;
      else if (wr_o && rt_addr_wb_o == rd_addr[gi])
        rd_next[gi] = rt_wb_o;
      else if (wr_e && rt_addr_wb_e == rd_addr[gi])
        rd_next[gi] = rt_wb_e;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) rd_data_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) rd_data_reg[i] <= rd_next[i];
    end
  end

  assign ra           = rd_data_reg[0];
  assign rb           = rd_data_reg[1];
  assign rc           = rd_data_reg[2];
  assign init_busy    = ~ready;
  assign wr_collision = collision_reg;

endmodule

// File: tb/tb_spu_reg_file.sv
// Directed bench for spu_reg_file: init sweep, bypass, collisions, dropped
// INIT writes and resets both mid-sweep and in normal operation.
module tb_spu_reg_file;
  logic         clk = 1'b0;
  logic         reset;
  logic [0:6]   ra_addr, rb_addr, rc_addr;
  logic [0:127] ra, rb, rc;
  logic [0:127] rt_wb_e, rt_wb_o;
  logic [0:6]   rt_addr_wb_e, rt_addr_wb_o;
  logic         reg_write_wb_e, reg_write_wb_o;
  logic         init_busy, wr_collision;

  int compared = 0;
  int mismatched = 0;

  localparam logic [127:0] V1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] V2 = 128'hDEADBEEFCAFEF00D1122334455667788;
  localparam logic [127:0] ALL_A = {32{4'hA}};
  localparam logic [127:0] ALL_5 = {32{4'h5}};
  localparam logic [127:0] ALL_F = {32{4'hF}};

  spu_reg_file #(.NUM_REGS(128), .DATA_W(128), .ADDR_W(7)) dut (
    .clk(clk), .reset(reset),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .ra(ra), .rb(rb), .rc(rc),
    .rt_wb_e(rt_wb_e), .rt_addr_wb_e(rt_addr_wb_e), .reg_write_wb_e(reg_write_wb_e),
    .rt_wb_o(rt_wb_o), .rt_addr_wb_o(rt_addr_wb_o), .reg_write_wb_o(reg_write_wb_o),
    .init_busy(init_busy), .wr_collision(wr_collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until init_busy falls; also flags any non-zero read output.
  task automatic wait_init(input string tag);
    int  n;
    logic nz;
    n  = 0;
    nz = 1'b0;
    while (init_busy && n < 300) begin
      tick();
      n++;
      if ((ra | rb | rc) != '0) nz = 1'b1;
    end
    check({tag, "_edges"}, 128'(n), 128'd128);
    check({tag, "_rd_zero"}, 128'(nz), 128'd0);
  endtask

  task automatic idle_wr();
    reg_write_wb_e = 1'b0;
    reg_write_wb_o = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    ra_addr = 7'd5; rb_addr = 7'd64; rc_addr = 7'd127;
    rt_wb_e = '0; rt_wb_o = '0; rt_addr_wb_e = '0; rt_addr_wb_o = '0;
    idle_wr();
    repeat (3) tick();
    check("rst_busy", 128'(init_busy), 128'd1);
    check("rst_coll", 128'(wr_collision), 128'd0);
    check("rst_ra", ra, 128'd0);

    // Release and walk the sweep edge by edge; write to r3 at edge 50 is dropped.
    reset = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      if (i == 50) begin
        reg_write_wb_e = 1'b1; rt_addr_wb_e = 7'd3; rt_wb_e = ALL_F;
      end
      tick();
      idle_wr();
      if (i == 127) check("init_busy_e127", 128'(init_busy), 128'd1);
      if (i == 128) check("init_busy_e128", 128'(init_busy), 128'd0);
      if (i == 64)  check("init_rb_zero", rb, 128'd0);
    end

    ra_addr = 7'd0; rb_addr = 7'd64; rc_addr = 7'd127;
    tick();
    check("rd_r0", ra, 128'd0);
    check("rd_r64", rb, 128'd0);
    check("rd_r127", rc, 128'd0);

    // Bypass: write r5 and read it on the same edge; r3 must still be zero.
    reg_write_wb_e = 1'b1; rt_addr_wb_e = 7'd5; rt_wb_e = V1;
    ra_addr = 7'd5; rc_addr = 7'd3;
    tick();
    idle_wr();
    check("bypass_r5", ra, V1);
    check("dropped_r3", rc, 128'd0);

    reg_write_wb_e = 1'b1; rt_wb_e = V2; ra_addr = 7'd0;
    tick();
    idle_wr();
    tick();
    ra_addr = 7'd5;
    tick();
    check("rewrite_r5", ra, V2);

    // Same-address collision: odd wins, one-cycle flag.
    reg_write_wb_e = 1'b1; rt_addr_wb_e = 7'd9; rt_wb_e = ALL_A;
    reg_write_wb_o = 1'b1; rt_addr_wb_o = 7'd9; rt_wb_o = ALL_5;
    rb_addr = 7'd9;
    tick();
    idle_wr();
    check("coll_rb", rb, ALL_5);
    check("coll_flag", 128'(wr_collision), 128'd1);
    tick();
    check("coll_flag_clr", 128'(wr_collision), 128'd0);
    check("coll_mem_r9", rb, ALL_5);

    // Back-to-back collisions hold the flag high.
    reg_write_wb_e = 1'b1; rt_addr_wb_e = 7'd10; rt_wb_e = ALL_A;
    reg_write_wb_o = 1'b1; rt_addr_wb_o = 7'd10; rt_wb_o = V1;
    tick();
    check("b2b_flag1", 128'(wr_collision), 128'd1);
    tick();
    idle_wr();
    check("b2b_flag2", 128'(wr_collision), 128'd1);
    tick();
    check("b2b_flag_clr", 128'(wr_collision), 128'd0);

    // Distinct addresses: both commit, no flag.
    reg_write_wb_e = 1'b1; rt_addr_wb_e = 7'd1; rt_wb_e = 128'd1;
    reg_write_wb_o = 1'b1; rt_addr_wb_o = 7'd2; rt_wb_o = 128'd2;
    tick();
    idle_wr();
    check("dual_flag", 128'(wr_collision), 128'd0);
    ra_addr = 7'd1; rb_addr = 7'd2; rc_addr = 7'd1;
    tick();
    check("dual_ra", ra, 128'd1);
    check("dual_rb", rb, 128'd2);
    check("dual_rc", rc, 128'd1);
    check("dual_flag2", 128'(wr_collision), 128'd0);

    // Even-only bypass overrides stale memory contents.
    reg_write_wb_e = 1'b1; rt_addr_wb_e = 7'd2; rt_wb_e = V1;
    tick();
    idle_wr();
    check("even_bypass_r2", rb, V1);

    // Reset in READY after writing r7.
    reg_write_wb_e = 1'b1; rt_addr_wb_e = 7'd7; rt_wb_e = 128'hFF;
    tick();
    idle_wr();
    ra_addr = 7'd7;
    tick();
    check("r7_written", ra, 128'hFF);
    reset = 1'b0;
    #1;
    check("async_ra", ra, 128'd0);
    check("async_busy", 128'(init_busy), 128'd1);
    tick();
    reset = 1'b1;
    wait_init("ready_rst");
    tick();
    check("r7_cleared", ra, 128'd0);

    // Reset at INIT edge 70: the sweep must restart from entry 0.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (70) tick();
    reset = 1'b0;
    #1;
    check("midinit_ra", ra, 128'd0);
    check("midinit_busy", 128'(init_busy), 128'd1);
    check("midinit_coll", 128'(wr_collision), 128'd0);
    tick();
    reset = 1'b1;
    wait_init("midinit_rst");
    ra_addr = 7'd9; rb_addr = 7'd5;
    tick();
    check("r9_cleared", ra, 128'd0);
    check("r5_cleared", rb, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
